mem_be_dp: RTL and testbench

MEM_BE_DP -- requirements
Module: mem_be_dp

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_rd_pipe.sv | 46 ++++
 rtl/mem_be_dp.sv | 129 ++++++++++++
 tb/tb_mem_be_dp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-enable dual-port memory.
package mem_pkg;

    // Controller states: normal operation or zero-fill sweep
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Same-address read-during-write policy
    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Legal read latency range
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-data delay line: RD_LAT registered stages of data plus valid.
// Each stage only loads data when its incoming valid is set, so the last
// stage holds the most recent read word while no read is emerging.
module mem_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  stg_vld [RD_LAT+1];
    logic [DATA_WIDTH-1:0] stg_dat [RD_LAT+1];

    assign stg_vld[0] = in_valid;
    assign stg_dat[0] = in_data;

    for (genvar g = 0; g < RD_LAT; g++) begin : g_stage
        logic                  vld_q;
        logic [DATA_WIDTH-1:0] dat_q;

        // One pipeline stage; reset discards any read in flight
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= stg_vld[g];
                if (stg_vld[g]) begin
                    dat_q <= stg_dat[g];
                end
            end
        end

        assign stg_vld[g+1] = vld_q;
        assign stg_dat[g+1] = dat_q;
    end

    assign out_valid = stg_vld[RD_LAT];
    assign out_data  = stg_dat[RD_LAT];

endmodule

// File: rtl/mem_be_dp.sv
// Simple dual-port RAM with per-byte write enables, configurable read
// latency, selectable read-during-write behaviour and a sequential
// zero-fill sweep that also runs automatically after every reset.
module mem_be_dp
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RDW_MODE   = RDW_OLD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    rd,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    input  logic                    clr,
    output logic                    busy
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Elaboration-time parameter sanity
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_data_width
        $error("mem_be_dp: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_be_dp: RD_LAT must be in 1..3");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw_mode
        $error("mem_be_dp: RDW_MODE must be 0 or 1");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clear_we_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_old_c;
    logic [DATA_WIDTH-1:0] wr_word_c;
    logic [DATA_WIDTH-1:0] rd_old_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    // State and sweep counter; reset lands in CLEAR so the array is zeroed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus request qualification; clr wins over wr/rd in IDLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clear_we_c = 1'b0;
        wr_acc_c   = 1'b0;
        rd_acc_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    wr_acc_c = wr && (|wbe);
                    rd_acc_c = rd;
                end
            end
            CLEAR: begin
                clear_we_c = 1'b1;
                cnt_d      = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // Byte-lane merge of new write data over the currently stored word
    assign wr_old_c = mem[waddr];
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        assign wr_word_c[8*g +: 8] = wbe[g] ? wdata[8*g +: 8] : wr_old_c[8*g +: 8];
    end

    // Read word; forward the merged word on a same-address collision if asked
    assign rd_old_c  = mem[raddr];
    assign rd_word_c = (RDW_MODE == RDW_NEW && wr_acc_c && (waddr == raddr)) ? wr_word_c
                                                                              : rd_old_c;

    // Storage array: sweep writes zero, otherwise accepted byte-masked writes
    always_ff @(posedge clk) begin
        if (clear_we_c) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc_c) begin
            mem[waddr] <= wr_word_c;
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc_c),
        .in_data   (rd_word_c),
        .out_valid (rvalid),
        .out_data  (rdata)
    );

endmodule

// File: tb/tb_mem_be_dp.sv
// Bench for mem_be_dp: two instances share stimulus, one with RD_LAT=1 and
// old-data collisions, one with RD_LAT=3 and new-data collisions.
module tb_mem_be_dp;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        rd;
    logic [7:0]  raddr;
    logic        clr;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        busy0, busy1;

    typedef struct {
        logic        wr;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        rd;
        logic [7:0]  raddr;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic [31:0] last0 = 32'h0;
    logic [31:0] last1 = 32'h0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    vec_t tab1 [14];
    vec_t tab2 [5];
    vec_t tab3 [2];

    mem_be_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LAT(LAT0), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rd(rd), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .clr(clr), .busy(busy0)
    );

    mem_be_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LAT(LAT1), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rd(rd), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .clr(clr), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard for instance 0
    always @(negedge clk) begin
        if (rvalid0) begin
            if (q0.size() == 0) begin
                check("rvalid0 unexpected", 32'(rvalid0), 32'h0);
            end else begin
                e0 = q0.pop_front();
                check("rdata0", rdata0, e0.data);
                check("rvalid0 cycle", 32'(cyc), 32'(e0.due));
                last0 = rdata0;
            end
        end else begin
            check("rdata0 hold", rdata0, last0);
        end
    end

    // Scoreboard for instance 1
    always @(negedge clk) begin
        if (rvalid1) begin
            if (q1.size() == 0) begin
                check("rvalid1 unexpected", 32'(rvalid1), 32'h0);
            end else begin
                e1 = q1.pop_front();
                check("rdata1", rdata1, e1.data);
                check("rvalid1 cycle", 32'(cyc), 32'(e1.due));
                last1 = rdata1;
            end
        end else begin
            check("rdata1 hold", rdata1, last1);
        end
    end

    task automatic zero_inputs();
        wr = 1'b0; waddr = 8'h0; wdata = 32'h0; wbe = 4'h0;
        rd = 1'b0; raddr = 8'h0; clr = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        zero_inputs();
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        wr = v.wr; waddr = v.waddr; wdata = v.wdata; wbe = v.wbe;
        rd = v.rd; raddr = v.raddr; clr = 1'b0;
        if (v.rd) begin
            q0.push_back('{v.exp_old, cyc + LAT0});
            q1.push_back('{v.exp_new, cyc + LAT1});
        end
    endtask

    // Counts sampled cycles with busy high, starting at the current negedge
    task automatic count_busy(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 600 && (busy0 || busy1); k++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n0, n1, k;

        //            wr    waddr  wdata         wbe      rd    raddr  exp_old       exp_new
        tab1[0]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'hFF, 32'h0,        32'h0};
        tab1[1]  = '{1'b1, 8'h0A, 32'hCAFEBABE, 4'hF,    1'b0, 8'h00, 32'h0,        32'h0};
        tab1[2]  = '{1'b1, 8'h0A, 32'h11223344, 4'b0101, 1'b0, 8'h00, 32'h0,        32'h0};
        tab1[3]  = '{1'b1, 8'h15, 32'hFFFFFFFF, 4'h0,    1'b0, 8'h00, 32'h0,        32'h0};
        tab1[4]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h0A, 32'hCA22BA44, 32'hCA22BA44};
        tab1[5]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h15, 32'h0,        32'h0};
        tab1[6]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h0A, 32'hCA22BA44, 32'hCA22BA44};
        tab1[7]  = '{1'b1, 8'h15, 32'h0ABCDEFE, 4'hF,    1'b1, 8'h15, 32'h0,        32'h0ABCDEFE};
        tab1[8]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h15, 32'h0ABCDEFE, 32'h0ABCDEFE};
        tab1[9]  = '{1'b1, 8'h15, 32'hFFFFFFFF, 4'b1000, 1'b1, 8'h15, 32'h0ABCDEFE, 32'hFFBCDEFE};
        tab1[10] = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h15, 32'hFFBCDEFE, 32'hFFBCDEFE};
        tab1[11] = '{1'b1, 8'h30, 32'h12345678, 4'b0011, 1'b1, 8'h30, 32'h0,        32'h00005678};
        tab1[12] = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h30, 32'h00005678, 32'h00005678};
        tab1[13] = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h14, 32'h0,        32'h0};

        tab2[0]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h20, 32'h0,        32'h0};
        tab2[1]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h0A, 32'h0,        32'h0};
        tab2[2]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h15, 32'h0,        32'h0};
        tab2[3]  = '{1'b1, 8'h20, 32'h55AA55AA, 4'hF,    1'b1, 8'h20, 32'h0,        32'h55AA55AA};
        tab2[4]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h20, 32'h55AA55AA, 32'h55AA55AA};

        tab3[0]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'h20, 32'h0,        32'h0};
        tab3[1]  = '{1'b0, 8'h00, 32'h0,        4'h0,    1'b1, 8'hFF, 32'h0,        32'h0};

        // Reset state
        zero_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset busy0", 32'(busy0), 32'h1);
        check("reset busy1", 32'(busy1), 32'h1);
        check("reset rvalid0", 32'(rvalid0), 32'h0);
        check("reset rvalid1", 32'(rvalid1), 32'h0);
        check("reset rdata0", rdata0, 32'h0);
        check("reset rdata1", rdata1, 32'h0);

        // Post-reset sweep length
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy(n0, n1);
        check("init clear busy0 cycles", 32'(n0), 32'd256);
        check("init clear busy1 cycles", 32'(n1), 32'd256);

        // Byte enables, back-to-back reads, collisions
        for (int i = 0; i < 14; i++) apply_vec(tab1[i]);
        idle();

        // Read in flight when clr arrives, then clr with a colliding wr/rd
        @(negedge clk);
        rd = 1'b1; raddr = 8'h0A;
        q0.push_back('{32'hCA22BA44, cyc + LAT0});
        q1.push_back('{32'hCA22BA44, cyc + LAT1});
        @(negedge clk);
        clr = 1'b1; wr = 1'b1; waddr = 8'h20; wdata = 32'hDEADBEEF; wbe = 4'hF;
        rd = 1'b1; raddr = 8'h0A;
        @(negedge clk);
        zero_inputs();
        n0 = 0; n1 = 0; k = 0;
        while ((busy0 || busy1) && k < 600) begin
            k++;
            if (busy0) n0++;
            if (busy1) n1++;
            if (k >= 2 && k <= 250) begin
                wr = 1'b1; waddr = 8'h20; wdata = 32'hFFFFFFFF; wbe = 4'hF;
                rd = 1'b1; raddr = 8'h20; clr = (k == 200);
            end else begin
                zero_inputs();
            end
            @(negedge clk);
        end
        zero_inputs();
        check("clr busy0 cycles", 32'(n0), 32'd256);
        check("clr busy1 cycles", 32'(n1), 32'd256);

        for (int i = 0; i < 5; i++) apply_vec(tab2[i]);
        idle();

        // Reset asserted while the sweep is about to write address 0x80
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        k = 0;
        while (busy0 && k < 600) begin
            k++;
            if (k == 129) break;
            @(negedge clk);
        end
        check("sweep reached 0x80", 32'(k), 32'd129);
        #1 rst_n = 1'b0;
        last0 = 32'h0;
        last1 = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n0, n1);
        check("mid-clear reset busy0 cycles", 32'(n0), 32'd256);
        check("mid-clear reset busy1 cycles", 32'(n1), 32'd256);

        // Reset asserted just after a read is accepted: it must vanish
        @(negedge clk);
        rd = 1'b1; raddr = 8'h20;
        @(posedge clk);
        #1 rst_n = 1'b0;
        rd = 1'b0;
        last0 = 32'h0;
        last1 = 32'h0;
        @(negedge clk);
        check("mid-read reset rdata0", rdata0, 32'h0);
        check("mid-read reset rdata1", rdata1, 32'h0);
        rst_n = 1'b1;
        count_busy(n0, n1);
        check("mid-read reset busy0 cycles", 32'(n0), 32'd256);
        check("mid-read reset busy1 cycles", 32'(n1), 32'd256);

        for (int i = 0; i < 2; i++) apply_vec(tab3[i]);
        idle();
        repeat (6) @(negedge clk);
        check("pending reads inst0", 32'(q0.size()), 32'h0);
        check("pending reads inst1", 32'(q1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
